// File: rtl/btn_debounce_array.sv
// btn_debounce_array: N-channel button synchroniser and debouncer with level, press/release and long-press outputs.
// Optional feature macro BTN_REPEAT_EN adds auto-repeat pulses after the long-press pulse.
module btn_debounce_array #(
  parameter int N_CH         = 4,
  parameter int TICK_DIV     = 100000,
  parameter int STABLE_CNT   = 4,
  parameter int HOLD_TICKS   = 500,
  parameter int REPEAT_TICKS = 100,
  parameter bit ACTIVE_LOW   = 1'b0
) (
  input  logic            i_clk,
  input  logic            i_reset_n,
  input  logic [N_CH-1:0] i_btn,
  output logic [N_CH-1:0] o_btn_level,
  output logic [N_CH-1:0] o_btn_posedge,
  output logic [N_CH-1:0] o_btn_negedge,
  output logic [N_CH-1:0] o_btn_hold,
  output logic [N_CH-1:0] o_btn_repeat,
  output logic            o_tick
);

  localparam int PW = $clog2(TICK_DIV);
  localparam int SW = $clog2(STABLE_CNT + 1);
  localparam int HW = $clog2(HOLD_TICKS + 1);

  localparam logic [PW-1:0] PRESC_LAST  = PW'(TICK_DIV - 1);
  localparam logic [PW-1:0] PRESC_PRE   = PW'(TICK_DIV - 2);
  localparam logic [SW-1:0] STABLE_LAST = SW'(STABLE_CNT - 1);
  localparam logic [HW-1:0] HOLD_MAX    = HW'(HOLD_TICKS);
  localparam logic [HW-1:0] HOLD_LAST   = HW'(HOLD_TICKS - 1);

`ifdef BTN_REPEAT_EN
  localparam int RW = $clog2(REPEAT_TICKS + 1);
  localparam logic [RW-1:0] REP_LAST = RW'(REPEAT_TICKS - 1);
`endif

  logic [PW-1:0] presc_reg;
  logic          tick_reg;

  // tick_reg is registered so it is high exactly while presc_reg == TICK_DIV-1
  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      presc_reg <= '0;
      tick_reg  <= 1'b0;
    end else begin
      if (presc_reg == PRESC_LAST) begin
        presc_reg <= '0;
      end else begin
        presc_reg <= presc_reg + PW'(1);
      end
      tick_reg <= (presc_reg == PRESC_PRE);
    end
  end

  assign o_tick = tick_reg;

  genvar gi;
  generate
    for (gi = 0; gi < N_CH; gi++) begin : g_ch
      logic          btn_pin;
      logic          sync1_reg;
      logic          sync2_reg;
      logic [SW-1:0] stab_reg;
      logic          level_reg;
      logic          posedge_reg;
      logic          negedge_reg;
      logic [HW-1:0] hold_reg;
      logic          hold_pulse_reg;
      logic          differ;
      logic          accept;
      logic          level_next;
      logic          stay_pressed;
      logic          hold_fire;

      // Polarity is fixed before the first flop so the reset value 0 always means "not pressed"
      assign btn_pin      = i_btn[gi] ^ ACTIVE_LOW;
      assign differ       = sync2_reg ^ level_reg;
      assign accept       = tick_reg & differ & (stab_reg == STABLE_LAST);
      assign level_next   = level_reg ^ accept;
      assign stay_pressed = level_reg & level_next;
      assign hold_fire    = tick_reg & stay_pressed & (hold_reg == HOLD_LAST);

      always_ff @(posedge i_clk) begin
        if (!i_reset_n) begin
          sync1_reg      <= 1'b0;
          sync2_reg      <= 1'b0;
          stab_reg       <= '0;
          level_reg      <= 1'b0;
          posedge_reg    <= 1'b0;
          negedge_reg    <= 1'b0;
          hold_reg       <= '0;
          hold_pulse_reg <= 1'b0;
        end else begin
          sync1_reg <= btn_pin;
          sync2_reg <= sync1_reg;
          if (tick_reg) begin
            stab_reg <= (differ && !accept) ? stab_reg + SW'(1) : '0;
          end
          level_reg      <= level_next;
          posedge_reg    <= accept & ~level_reg;
          negedge_reg    <= accept & level_reg;
          hold_pulse_reg <= hold_fire;
          // The press-accept and release-accept ticks both leave the hold count at zero
          if (!stay_pressed) begin
            hold_reg <= '0;
          end else if (tick_reg && (hold_reg != HOLD_MAX)) begin
            hold_reg <= hold_reg + HW'(1);
          end
        end
      end

      assign o_btn_level[gi]   = level_reg;
      assign o_btn_posedge[gi] = posedge_reg;
      assign o_btn_negedge[gi] = negedge_reg;
      assign o_btn_hold[gi]    = hold_pulse_reg;

`ifdef BTN_REPEAT_EN
      logic [RW-1:0] rep_reg;
      logic          rep_pulse_reg;

      // Repeat counting starts only once the hold count has saturated
      always_ff @(posedge i_clk) begin
        if (!i_reset_n) begin
          rep_reg       <= '0;
          rep_pulse_reg <= 1'b0;
        end else begin
          rep_pulse_reg <= 1'b0;
          if (!stay_pressed || hold_fire) begin
            rep_reg <= '0;
          end else if (tick_reg && (hold_reg == HOLD_MAX)) begin
            if (rep_reg == REP_LAST) begin
              rep_reg       <= '0;
              rep_pulse_reg <= 1'b1;
            end else begin
              rep_reg <= rep_reg + RW'(1);
            end
          end
        end
      end

      assign o_btn_repeat[gi] = rep_pulse_reg;
`else
      assign o_btn_repeat[gi] = 1'b0;
`endif
    end
  endgenerate

endmodule
